virtio_csr_axil_slave: RTL and testbench
========================================

# virtio_csr_axil_slave

AXI4-Lite responder for the bridge's control/status register space, the target end of the CSR initialisation path that host-side and simulation masters drive. It decodes single-beat reads and writes into a small register file. It exposes enable, soft-reset, doorbell and interrupt signals to the virtio datapath. It sits behind the PCIe bridge's AXI-Lite BAR port, in the same clock domain as the DMA engine.

## Interface
- ADDR_W, 12, byte-address width; only bits [4:2] decoded, bits [ADDR_W-1:5] must be zero for a hit.
- DEV_ID, 32'h1AF4_1041, value returned by the ID register.
- axi_aclk  in  1  sole clock; all logic on rising edge.
- axi_aresetn  in  1  asynchronous, active-low reset.
- s_axil_awaddr  in  ADDR_W  write address.
- s_axil_awvalid / s_axil_awready  in / out  1  write-address handshake.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid / s_axil_wready  in / out  1  write-data handshake.
- s_axil_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axil_bvalid / s_axil_bready  out / in  1  write-response handshake.
- s_axil_araddr  in  ADDR_W  read address.
- s_axil_arvalid / s_axil_arready  in / out  1  read-address handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out / in  1  read-data handshake.
- busy_i  in  1  datapath busy, reflected in STATUS.
- irq_set_i  in  4  per-source interrupt set pulses.
- irq_o  out  1  registered OR of enabled pending interrupts.
- ctrl_enable_o  out  1  CTRL.bit0.
- soft_rst_o  out  1  one-cycle pulse.
- doorbell_valid_o  out  1  one-cycle pulse.
- doorbell_data_o  out  16  queue index of the last doorbell.

## Operation
- Register map:
  - 0x00 ID: RO, returns DEV_ID.
  - 0x04 CTRL: bit0 enable (RW). Bit1 soft reset: write 1 pulses soft_rst_o; reads 0.
  - 0x08 STATUS: RO, {31'b0, busy_i}.
  - 0x0C IRQ_STATUS: [3:0], W1C.
  - 0x10 IRQ_MASK: [3:0], RW.
  - 0x14 DOORBELL: WO, reads 0. A write loads wdata[15:0] into doorbell_data_o and pulses doorbell_valid_o.
  - 0x18 SCRATCH: 32-bit RW.
  - 0x1C and any address with nonzero upper bits: unmapped. Writes are dropped with SLVERR; reads return 0 with SLVERR.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: when awvalid and wvalid are both high, assert awready and wready together for one cycle, commit the register update, and go to W_RESP.
  - W_RESP: bvalid held high until bready, then return to W_IDLE.
  - AW without W, or W without AW: no handshake; wait.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready is high. On arvalid, capture rdata/rresp and go to R_DATA.
  - R_DATA: rvalid held with stable data until rready. arready is low.
- The read and write channels are fully independent; a simultaneous read and write both proceed. A read of a register written in the same cycle returns the pre-write value.
- IRQ_STATUS next value = (cur & ~w1c_mask) | irq_set_i. A set and a clear on the same bit in the same cycle: set wins.
- irq_o = |(IRQ_STATUS & IRQ_MASK), registered.

## Timing
- Reset values of outputs:
  - all ready, valid and pulse outputs 0, except arready = 1;
  - bresp, rresp and rdata are 0;
  - ctrl_enable_o = 0, doorbell_data_o = 0, irq_o = 0.
- Reset values of registers: IRQ_STATUS, IRQ_MASK and SCRATCH are 0.
- Write latency: AW/W handshake at cycle N; register, soft_rst_o and doorbell_valid_o change at N+1; bvalid rises at N+1.
- Read latency: AR handshake at cycle N; rvalid rises at N+1.
- irq_o follows an IRQ_STATUS or IRQ_MASK change by one cycle.
- Throughput: at most one write per 2 cycles and one read per 2 cycles when bready/rready are tied high.
- Reset asserted mid-transaction aborts it. The outputs above return to their reset values immediately; a pending response is lost.

## Configuration
- VIRTIO_CSR_WSTRB_EN:
  - Defined: each byte lane of CTRL, IRQ_MASK, SCRATCH and DOORBELL updates only where wstrb is set. W1C acts only on strobed lanes. A DOORBELL write fires only if wstrb[1:0] == 2'b11.
  - Undefined: wstrb is ignored and every write is a full-word write.

## Test plan
- Reset, then read 0x00 -> rdata 32'h1AF4_1041, OKAY; read 0x1C -> rdata 0, SLVERR.
- Write 0x18 = 32'hDEAD_BEEF then read it back -> 32'hDEAD_BEEF. With VIRTIO_CSR_WSTRB_EN defined, write 32'h0 with wstrb 4'b0011 -> readback 32'hDEAD_0000.
- Present AW 3 cycles before W -> awready and wready rise together on the first cycle both are valid; hold bready low 5 cycles -> bvalid stays high, OKAY.
- IRQ path:
  - Set IRQ_MASK = 4'h5 and pulse irq_set_i = 4'hF -> IRQ_STATUS reads 4'hF and irq_o = 1 one cycle later.
  - Write 1s in IRQ_STATUS bits 0 and 2 (0x5) in the same cycle as irq_set_i = 4'h1 -> IRQ_STATUS reads 4'hB and irq_o stays 1.
- Write 0x14 = 32'h0000_0007 -> a single doorbell_valid_o pulse with doorbell_data_o = 16'h0007. Write 0x04 = 32'h3 -> ctrl_enable_o = 1, a one-cycle soft_rst_o pulse, and CTRL reads 32'h1.
- Drop axi_aresetn while rvalid is held waiting for rready -> rvalid = 0 and arready = 1 immediately, and all registers return to their reset values.

Source files
------------

// File: rtl/virtio_csr_axil_slave.sv
// AXI4-Lite CSR responder for the virtio bridge: ID/CTRL/STATUS/IRQ/DOORBELL/SCRATCH registers.
// Optional byte-strobe support is enabled with `define VIRTIO_CSR_WSTRB_EN.
module virtio_csr_axil_slave #(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] DEV_ID = 32'h1AF4_1041
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  input  logic              busy_i,
  input  logic [3:0]        irq_set_i,
  output logic              irq_o,
  output logic              ctrl_enable_o,
  output logic              soft_rst_o,
  output logic              doorbell_valid_o,
  output logic [15:0]       doorbell_data_o
);

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  localparam logic [2:0] A_ID       = 3'd0;
  localparam logic [2:0] A_CTRL     = 3'd1;
  localparam logic [2:0] A_STATUS   = 3'd2;
  localparam logic [2:0] A_IRQ_ST   = 3'd3;
  localparam logic [2:0] A_IRQ_MSK  = 3'd4;
  localparam logic [2:0] A_DOORBELL = 3'd5;
  localparam logic [2:0] A_SCRATCH  = 3'd6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_t    w_state, w_state_nxt;
  r_state_t    r_state, r_state_nxt;
  logic        w_fire, r_fire;
  logic        wr_hit, rd_hit;
  logic [2:0]  waddr, raddr;
  logic [31:0] wmask;
  logic        db_ok;
  logic [31:0] rd_word;
  logic [3:0]  irq_status, irq_mask, w1c, irq_nxt;
  logic [31:0] scratch;
  logic        unused_bits;

  // Upper address bits must be zero and 0x1C is a hole.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    return (a[ADDR_W-1:5] == '0) && (a[4:2] != 3'd7);
  endfunction

  assign waddr  = s_axil_awaddr[4:2];
  assign raddr  = s_axil_araddr[4:2];
  assign wr_hit = addr_hit(s_axil_awaddr);
  assign rd_hit = addr_hit(s_axil_araddr);

`ifdef VIRTIO_CSR_WSTRB_EN
  assign wmask = {{8{s_axil_wstrb[3]}}, {8{s_axil_wstrb[2]}},
                  {8{s_axil_wstrb[1]}}, {8{s_axil_wstrb[0]}}};
  assign db_ok = &s_axil_wstrb[1:0];
  assign unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
`else
  assign wmask = '1;
  assign db_ok = 1'b1;
  assign unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_wstrb};
`endif

  // Write channel
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) w_state <= W_IDLE;
    else              w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = w_state;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    w_fire         = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s_axil_awvalid && s_axil_wvalid) begin
          s_axil_awready = 1'b1;
          s_axil_wready  = 1'b1;
          w_fire         = 1'b1;
          w_state_nxt    = W_RESP;
        end
      end
      W_RESP: begin
        s_axil_bvalid = 1'b1;
        if (s_axil_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)  s_axil_bresp <= RESP_OKAY;
    else if (w_fire)   s_axil_bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
  end

  // Read channel
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= R_IDLE;
    else              r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt    = r_state;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    r_fire         = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axil_arready = 1'b1;
        if (s_axil_arvalid) begin
          r_fire      = 1'b1;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        s_axil_rvalid = 1'b1;
        if (s_axil_rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      case (raddr)
        A_ID:      rd_word = DEV_ID;
        A_CTRL:    rd_word = {31'b0, ctrl_enable_o};
        A_STATUS:  rd_word = {31'b0, busy_i};
        A_IRQ_ST:  rd_word = {28'b0, irq_status};
        A_IRQ_MSK: rd_word = {28'b0, irq_mask};
        A_SCRATCH: rd_word = scratch;
        default:   rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      s_axil_rdata <= '0;
      s_axil_rresp <= RESP_OKAY;
    end else if (r_fire) begin
      s_axil_rdata <= rd_word;
      s_axil_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Set wins over a same-cycle clear.
  always_comb begin
    w1c = '0;
    if (w_fire && wr_hit && (waddr == A_IRQ_ST)) w1c = s_axil_wdata[3:0] & wmask[3:0];
    irq_nxt = (irq_status & ~w1c) | irq_set_i;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ctrl_enable_o    <= 1'b0;
      soft_rst_o       <= 1'b0;
      doorbell_valid_o <= 1'b0;
      doorbell_data_o  <= '0;
      irq_status       <= '0;
      irq_mask         <= '0;
      irq_o            <= 1'b0;
      scratch          <= '0;
    end else begin
      soft_rst_o       <= 1'b0;
      doorbell_valid_o <= 1'b0;
      irq_status       <= irq_nxt;
      irq_o            <= |(irq_status & irq_mask);
      if (w_fire && wr_hit) begin
        case (waddr)
          A_CTRL: begin
            if (wmask[0]) ctrl_enable_o <= s_axil_wdata[0];
            if (wmask[1] && s_axil_wdata[1]) soft_rst_o <= 1'b1;
          end
          A_IRQ_MSK: irq_mask <= (irq_mask & ~wmask[3:0]) | (s_axil_wdata[3:0] & wmask[3:0]);
          A_DOORBELL: begin
            if (db_ok) begin
              doorbell_data_o  <= s_axil_wdata[15:0];
              doorbell_valid_o <= 1'b1;
            end
          end
          A_SCRATCH: scratch <= (scratch & ~wmask) | (s_axil_wdata & wmask);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_virtio_csr_axil_slave.sv
// Self-checking bench for virtio_csr_axil_slave using response scoreboards for the B and R channels.
module tb_virtio_csr_axil_slave;

  localparam logic [31:0] DEV_ID = 32'h1AF4_1041;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        busy = 1'b0;
  logic [3:0]  irq_set = '0;
  logic        irq, ctrl_enable, soft_rst, doorbell_valid;
  logic [15:0] doorbell_data;

  int n_cmp = 0;
  int n_err = 0;
  int db_cnt = 0;
  int sr_cnt = 0;
  logic [31:0] scr_model = '0;

  logic [1:0]  wq[$];
  logic [33:0] rq[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (doorbell_valid) db_cnt <= db_cnt + 1;
    if (soft_rst)       sr_cnt <= sr_cnt + 1;
  end

  virtio_csr_axil_slave #(.ADDR_W(12), .DEV_ID(DEV_ID)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .busy_i(busy), .irq_set_i(irq_set), .irq_o(irq), .ctrl_enable_o(ctrl_enable),
    .soft_rst_o(soft_rst), .doorbell_valid_o(doorbell_valid), .doorbell_data_o(doorbell_data)
  );

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [3:0] irq_pulse, input logic [1:0] exp, input string name);
    int n;
    logic [1:0] e;
    wq.push_back(exp);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; irq_set = irq_pulse;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) begin n_cmp++; n_err++; $display("FAIL %s aw/w handshake timeout", name); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; irq_set = '0; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    e = wq.pop_front();
    n_cmp++;
    if (!bvalid || bresp !== e) begin
      n_err++;
      $display("FAIL %s bresp got %b (bvalid %b) expected %b", name, bresp, bvalid, e);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                          input string name);
    int n;
    logic [33:0] e;
    rq.push_back({exp_d, exp_r});
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) begin n_cmp++; n_err++; $display("FAIL %s ar handshake timeout", name); end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    e = rq.pop_front();
    n_cmp++;
    if (!rvalid || rdata !== e[33:2] || rresp !== e[1:0]) begin
      n_err++;
      $display("FAIL %s read got %h/%b (rvalid %b) expected %h/%b", name, rdata, rresp, rvalid,
               e[33:2], e[1:0]);
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = {arready, awready, wready, bvalid, rvalid, soft_rst, doorbell_valid, irq};
    n_cmp++;
    if (got !== 8'b1000_0000) begin
      n_err++; $display("FAIL reset_ctrl_outputs got %b expected %b", got, 8'b1000_0000);
    end
    n_cmp++;
    if ({ctrl_enable, doorbell_data, rdata, bresp, rresp} !== '0) begin
      n_err++;
      $display("FAIL reset_data_outputs got en=%b db=%h rdata=%h bresp=%b rresp=%b expected all 0",
               ctrl_enable, doorbell_data, rdata, bresp, rresp);
    end
  endtask

  task automatic test_decode();
    axi_read(12'h000, DEV_ID, OKAY, "read_id");
    axi_read(12'h01C, 32'h0, SLVERR, "read_hole");
    axi_read(12'h100, 32'h0, SLVERR, "read_upper");
    axi_write(12'h01C, 32'h1234_5678, 4'hF, 4'h0, SLVERR, "write_hole");
    axi_write(12'h118, 32'h1234_5678, 4'hF, 4'h0, SLVERR, "write_upper");
    axi_read(12'h018, 32'h0, OKAY, "scratch_not_aliased");
    busy = 1'b1;
    axi_read(12'h008, 32'h1, OKAY, "status_busy1");
    busy = 1'b0;
    axi_read(12'h008, 32'h0, OKAY, "status_busy0");
  endtask

  task automatic test_scratch();
    axi_write(12'h018, 32'hDEAD_BEEF, 4'hF, 4'h0, OKAY, "scratch_wr");
    scr_model = 32'hDEAD_BEEF;
    axi_read(12'h018, scr_model, OKAY, "scratch_rd");
    axi_write(12'h018, 32'h0, 4'b0011, 4'h0, OKAY, "scratch_wr_strb");
`ifdef VIRTIO_CSR_WSTRB_EN
    scr_model = 32'hDEAD_0000;
`else
    scr_model = 32'h0;
`endif
    axi_read(12'h018, scr_model, OKAY, "scratch_rd_strb");
  endtask

  task automatic test_aw_before_w();
    logic [1:0] e;
    wq.push_back(OKAY);
    @(negedge clk);
    awaddr = 12'h018; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    repeat (3) begin
      #1;
      n_cmp++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        n_err++; $display("FAIL aw_only_ready got aw=%b w=%b expected 0/0", awready, wready);
      end
      @(negedge clk);
    end
    wvalid = 1'b1;
    #1;
    n_cmp++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      n_err++; $display("FAIL aw_w_ready got aw=%b w=%b expected 1/1", awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (bvalid !== 1'b1) begin n_err++; $display("FAIL bvalid_hold got %b expected 1", bvalid); end
    end
    e = wq.pop_front();
    n_cmp++;
    if (bresp !== e) begin n_err++; $display("FAIL aw_first_bresp got %b expected %b", bresp, e); end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bvalid !== 1'b0) begin n_err++; $display("FAIL bvalid_drop got %b expected 0", bvalid); end
    scr_model = 32'hCAFE_F00D;
    axi_read(12'h018, scr_model, OKAY, "aw_first_scratch");
  endtask

  task automatic test_irq();
    axi_write(12'h010, 32'h5, 4'hF, 4'h0, OKAY, "mask_wr");
    axi_read(12'h010, 32'h5, OKAY, "mask_rd");
    @(negedge clk);
    irq_set = 4'hF;
    @(negedge clk);
    irq_set = 4'h0;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_latency got %b expected 0", irq); end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_raise got %b expected 1", irq); end
    axi_read(12'h00C, 32'hF, OKAY, "irq_status_F");
    axi_write(12'h00C, 32'h5, 4'hF, 4'h1, OKAY, "w1c_with_set");
    axi_read(12'h00C, 32'hB, OKAY, "irq_status_B");
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_stays got %b expected 1", irq); end
    axi_write(12'h00C, 32'hF, 4'hF, 4'h0, OKAY, "w1c_all");
    axi_read(12'h00C, 32'h0, OKAY, "irq_status_0");
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got %b expected 0", irq); end
  endtask

  task automatic test_doorbell_ctrl();
    int db0, sr0;
    db0 = db_cnt;
    axi_write(12'h014, 32'h0000_0007, 4'hF, 4'h0, OKAY, "doorbell_wr");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (db_cnt - db0 !== 1 || doorbell_data !== 16'h0007) begin
      n_err++;
      $display("FAIL doorbell got pulses=%0d data=%h expected 1/0007", db_cnt - db0, doorbell_data);
    end
    axi_read(12'h014, 32'h0, OKAY, "doorbell_rd");
`ifdef VIRTIO_CSR_WSTRB_EN
    db0 = db_cnt;
    axi_write(12'h014, 32'h0000_0009, 4'b0001, 4'h0, OKAY, "doorbell_partial");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (db_cnt - db0 !== 0 || doorbell_data !== 16'h0007) begin
      n_err++;
      $display("FAIL doorbell_partial got pulses=%0d data=%h expected 0/0007", db_cnt - db0, doorbell_data);
    end
`endif
    sr0 = sr_cnt;
    axi_write(12'h004, 32'h3, 4'hF, 4'h0, OKAY, "ctrl_wr");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ctrl_enable !== 1'b1 || sr_cnt - sr0 !== 1) begin
      n_err++;
      $display("FAIL ctrl got en=%b soft_rst_cycles=%0d expected 1/1", ctrl_enable, sr_cnt - sr0);
    end
    axi_read(12'h004, 32'h1, OKAY, "ctrl_rd");
  endtask

  task automatic test_back_to_back();
    logic [31:0] old;
    old = scr_model;
    fork
      axi_write(12'h018, 32'h1234_5678, 4'hF, 4'h0, OKAY, "b2b_wr");
      axi_read(12'h018, old, OKAY, "b2b_rd_old");
    join
    scr_model = 32'h1234_5678;
    axi_read(12'h018, scr_model, OKAY, "b2b_rd_new");
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    irq_set = 4'h2;
    @(negedge clk);
    irq_set = 4'h0;
    araddr = 12'h018; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (rvalid !== 1'b1 || arready !== 1'b0) begin
      n_err++; $display("FAIL mid_pending got rvalid=%b arready=%b expected 1/0", rvalid, arready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rdata !== 32'h0) begin
      n_err++;
      $display("FAIL mid_rst_read got rvalid=%b arready=%b rdata=%h expected 0/1/0", rvalid, arready, rdata);
    end
    n_cmp++;
    if (ctrl_enable !== 1'b0 || doorbell_data !== 16'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_regs got en=%b db=%h irq=%b expected 0/0000/0", ctrl_enable, doorbell_data, irq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    scr_model = '0;
    axi_read(12'h018, 32'h0, OKAY, "post_rst_scratch");
    axi_read(12'h010, 32'h0, OKAY, "post_rst_mask");
    axi_read(12'h00C, 32'h0, OKAY, "post_rst_irq_status");
    axi_read(12'h004, 32'h0, OKAY, "post_rst_ctrl");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_scratch();
    test_aw_before_w();
    test_irq();
    test_doorbell_ctrl();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
